mdu_iter: RTL

- Iterative multiply/divide unit alongside the ALU in the execute stage.
- Consumes the forwarded execute-stage operands (rs path, rt path after forwarding) and holds the architectural HI/LO pair.
- Memory-stage pipeline registers and the writeback path read HI/LO.
- Asserts busy so the main controller stalls dependent instructions (mult/div/mfhi/mflo/mthi/mtlo) in decode.

---
 rtl/mdu_iter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage.
// Owns the HI/LO pair and holds busy for a fixed number of cycles per mult/div.
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [31:0]        a_q, b_q;
  logic               accept, go_long, is_mult, finish;

  assign accept  = start && (state == IDLE) && (op >= OP_MULT) && (op <= OP_MTLO);
  assign go_long = accept && (op <= OP_DIVU);
  assign is_mult = (op == OP_MULT) || (op == OP_MULTU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (go_long) next_state = RUN;
      RUN:  if (cnt == CNT_W'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    finish = (state == RUN) && (cnt == CNT_W'(1));
  end

  // Counter and operand capture; operands are frozen for the whole busy window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (go_long) begin
      cnt  <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end else if (state == RUN) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  logic [63:0] prod_u, prod_s, prod;
  logic        sdiv, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod   = (op_q == OP_MULT) ? prod_s : prod_u;
  end

  // Signed divide works on magnitudes so the overflow case falls out naturally.
  always_comb begin
    sdiv     = (op_q == OP_DIV);
    a_neg    = sdiv && a_q[31];
    b_neg    = sdiv && b_q[31];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = (b_q == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end else if (!div_zero) begin
        hi <= rem;
        lo <= quot;
      end
    end else if (accept && (op == OP_MTHI)) begin
      hi <= a;
    end else if (accept && (op == OP_MTLO)) begin
      lo <= a;
    end
  end

endmodule
